// File: rtl/mux_nto1_stream_pkg.sv
// Shared definitions for the N:1 stream multiplexer: mode constants, lock FSM states, clog2 helper.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1_stream_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward (mod NUM_CH) for the first request.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_id
);

  int   idx;
  logic found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= NUM_CH; off++) begin
      idx = (int'(ptr) + off) % NUM_CH;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = SEL_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-channel registered stream mux with fixed-select or round-robin arbitration.
// Optional packet lock (hold grant until in_last) is enabled by defining MUX_PKT_LOCK_EN.
module mux_nto1_stream
  import mux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] rr_grant;
  logic [SEL_W-1:0]  rr_id;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_id;
  logic              load;
  logic              accept;

  rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
    .req      (in_valid),
    .ptr      (rr_ptr),
    .grant    (rr_grant),
    .grant_id (rr_id)
  );

`ifdef MUX_PKT_LOCK_EN
  lock_state_t      lock_state;
  logic [SEL_W-1:0] lock_ch;
  logic             locked;

  assign locked = (lock_state == LOCK_LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state <= LOCK_IDLE;
      lock_ch    <= '0;
    end else if (accept) begin
      case (lock_state)
        LOCK_IDLE: if (!in_last[grant_id]) begin
          lock_state <= LOCK_LOCKED;
          lock_ch    <= grant_id;
        end
        LOCK_LOCKED: if (in_last[lock_ch]) lock_state <= LOCK_IDLE;
        default: lock_state <= LOCK_IDLE;
      endcase
    end
  end
`else
  logic             locked;
  logic [SEL_W-1:0] lock_ch;
  logic             unused_last;

  assign locked      = 1'b0;
  assign lock_ch     = '0;
  assign unused_last = ^in_last;
`endif

  // A locked packet overrides both the mode and the round-robin priority.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    if (locked) begin
      grant[lock_ch] = in_valid[lock_ch];
      grant_id       = lock_ch;
    end else if (mode == MODE_RR) begin
      grant    = rr_grant;
      grant_id = rr_id;
    end else if (int'(sel) < NUM_CH) begin
      grant[sel] = in_valid[sel];
      grant_id   = sel;
    end
  end

  assign load     = !out_valid || out_ready;
  assign in_ready = grant & {NUM_CH{load}};
  assign accept   = (|grant) && load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant_id)*WIDTH +: WIDTH];
      out_ch    <= grant_id;
      rr_ptr    <= grant_id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed self-checking bench for mux_nto1_stream (packet-lock steps only when MUX_PKT_LOCK_EN is defined).
module tb_mux_nto1_stream;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [NUM_CH-1:0]       in_last;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;

  int checks   = 0;
  int failures = 0;

  mux_nto1_stream #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ch, input logic [31:0] data);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_ch"},    32'(out_ch),    ch);
    chk({tag, "_data"},  32'(out_data),  data);
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_ch",    32'(out_ch),    32'd0);
    rst = 1'b0;

    // Round robin, all channels valid: 0,1,2,3,0
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'h1);
    step(); chk_out("rr0", 0, 32'h11);
    chk("rr_next_ready", 32'(in_ready), 32'h2);
    step(); chk_out("rr1", 1, 32'h22);
    step(); chk_out("rr2", 2, 32'hA5);
    step(); chk_out("rr3", 3, 32'h44);
    step(); chk_out("rr4", 0, 32'h11);
    step(); chk_out("rr5", 1, 32'h22);

    // Reset mid-stream drops output immediately, then ch0 wins first again
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data",  32'(out_data),  32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("postrst_ready", 32'(in_ready), 32'h1);
    step(); chk_out("postrst", 0, 32'h11);

    // Only ch1 and ch3 valid: 1,3,1,3
    in_valid = 4'b1010;
    step(); chk_out("sp0", 1, 32'h22);
    step(); chk_out("sp1", 3, 32'h44);
    step(); chk_out("sp2", 1, 32'h22);
    step(); chk_out("sp3", 3, 32'h44);

    // Fixed mode sel=2
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b1111;
    #1;
    chk("fix_ready", 32'(in_ready), 32'h4);
    step(); chk_out("fix", 2, 32'hA5);

    // Backpressure for 3 cycles while ch2 offers a new beat
    out_ready = 1'b0;
    in_data   = {8'h44, 8'h5A, 8'h22, 8'h11};
    #1;
    chk("bp_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("bp_hold", 2, 32'hA5);
      chk("bp_hold_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(in_ready), 32'h4);
    step(); chk_out("bp_resume", 2, 32'h5A);

    // Fixed sel=3 with ch3 idle: output drains, nothing else granted
    sel      = 2'd3;
    in_valid = 4'b0011;
    #1;
    chk("idle_ready", 32'(in_ready), 32'h0);
    step();
    chk("drain_valid0", 32'(out_valid), 32'd0);
    step();
    chk("drain_valid1", 32'(out_valid), 32'd0);
    chk("drain_ch", 32'(out_ch), 32'd2);

`ifdef MUX_PKT_LOCK_EN
    // ch1 sends a 3-beat packet while ch0 and ch2 are also valid
    rst = 1'b1;
    step();
    rst      = 1'b0;
    mode     = 1'b1;
    in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    step(); chk_out("pkt_b1", 1, 32'h22);
    in_valid = 4'b0111;
    #1;
    chk("pkt_lock_ready", 32'(in_ready), 32'h2);
    step(); chk_out("pkt_b2", 1, 32'h22);
    in_last = 4'b0010;
    step(); chk_out("pkt_b3", 1, 32'h22);
    in_last = 4'b0000;
    step(); chk_out("pkt_after", 2, 32'hA5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
